sobel_window_conv: RTL and testbench
====================================

# sobel_window_conv

Streaming 3x3 Sobel convolution stage for the edge-detection pipeline. Accepts 8-bit grayscale pixels in raster order and buffers two image rows in line buffers. Forms a 3x3 window per interior pixel and emits the horizontal and vertical gradients gx and gy as 11-bit values. Sits directly upstream of the gradient-magnitude stage, which consumes gx and gy and produces the 8-bit saturated edge value.

## Interface
- IMG_WIDTH, 640, pixels per row (≥3)
- IMG_HEIGHT, 480, rows per frame (≥3)
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous and active-high
- in_pix  input  8  grayscale pixel
- in_valid  input  1  in_pix valid
- in_sof  input  1  qualifies the first pixel of a frame; sampled with in_valid
- in_ready  output  1  stage can accept a pixel this cycle
- gx  output  11  signed horizontal gradient
- gy  output  11  signed vertical gradient
- out_valid  output  1  gx/gy valid
- out_last  output  1  final output of the frame
- out_ready  input  1  downstream accepts gx/gy

## Operation
- Accept: an input pixel is accepted when in_valid && in_ready.
- Counters: col and row track the accepted pixel.
  - col wraps at IMG_WIDTH-1; row increments on col wrap and wraps at IMG_HEIGHT-1.
  - An accepted pixel with in_sof forces that pixel to (row 0, col 0), so counters resync mid-frame.
- Line buffers: two chained row delays of depth IMG_WIDTH supply the pixels from the two previous rows at the same column.
- Window: the 3x3 shift window p[i][j] holds rows i = 0..2 (0 oldest) and columns j = 0..2 (0 leftmost). It shifts on every accepted pixel.
- Output condition: a window is emitted only when the accepted pixel has row ≥ 2 and col ≥ 2. The emitted window is centred on (row-1, col-1). This gives (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs per frame; border pixels produce no output.
- Arithmetic, full 11-bit signed with no saturation (max |gx|, |gy| = 1020):
  - gx = (p02 + 2·p12 + p22) - (p00 + 2·p10 + p20)
  - gy = (p20 + 2·p21 + p22) - (p00 + 2·p01 + p02)
- out_last is asserted with the output whose accepted pixel was (IMG_HEIGHT-1, IMG_WIDTH-1).
- Reset values: in_ready 1 (the stage is enabled, see en in Timing); gx 0, gy 0, out_valid 0, out_last 0; counters 0.
- Line buffer contents are not cleared by rst. This is safe because rows 0–1 of every frame refill them before any output is produced.

## Timing
- Two-stage pipeline:
  - S1: window register plus output-condition flag.
  - S2: gx/gy/out_last registers plus out_valid.
- Global enable: en = !out_valid || out_ready. in_ready = en (combinational). Both stages and the line buffers advance only when en is high.
- Latency: a pixel accepted at cycle t with no stall produces out_valid at t+2.
- Stall: while out_valid && !out_ready, gx, gy, out_valid and out_last hold stable and in_ready is 0.
- A bubble (no accepted pixel) clears the S1 valid flag. S2 drains when en is high.
- Simultaneous in_sof and a counter wrap: in_sof wins.
- rst mid-frame: pipeline valids clear next cycle, and the next frame must begin with in_sof.

## Configuration
- SOBEL_ABS_EN defined: gx and gy are output as absolute values in 0..1020, with bit 10 always 0. This matches a downstream stage that adds gx + gy unsigned.
- SOBEL_ABS_EN undefined: raw two's-complement gx and gy in -1020..1020.

## Structure
- Package sobel_pkg holds:
  - PIX_W = 8 and GRAD_W = 11
  - a window typedef (3x3 array of PIX_W)
  - the default image dimensions
- Sub-module sobel_line_buffer: a single-row delay of parameterised depth with an enable. It is instantiated twice.

## Test plan
- Constant 100-valued 8x6 frame -> 24 outputs, all gx = gy = 0; out_last on the 24th.
- 8x6 vertical step (cols 0–3 = 0, cols 4–7 = 255) -> gx = 1020, gy = 0 for window centre cols 3 and 4; 0 elsewhere.
- Inverse step (255 | 0) -> gx = -1020 without SOBEL_ABS_EN; gx = 1020 with it.
- Horizontal step (rows 0–2 = 0, rows 3–5 = 255) -> gy = 1020 at centre rows 2 and 3; gx = 0.
- out_ready held low for 5 cycles mid-frame -> in_ready low, outputs stable, no data lost or duplicated; output sequence identical to the unstalled run.
- in_sof reasserted after 13 pixels of a frame -> counters resync; the next full frame yields exactly 24 correct outputs with out_last on the 24th.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared widths, 3x3 window type and default frame size for the Sobel stage.
// Helpers widen pixels into the signed gradient domain.
package sobel_pkg;
  localparam int PIX_W          = 8;
  localparam int GRAD_W         = 11;
  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  // [row 0 oldest .. 2 newest][col 0 leftmost .. 2 rightmost]
  typedef logic [2:0][2:0][PIX_W-1:0] window_t;

  function automatic logic signed [GRAD_W-1:0] pix_ext(input logic [PIX_W-1:0] v);
    return $signed({{(GRAD_W-PIX_W){1'b0}}, v});
  endfunction

  function automatic logic signed [GRAD_W-1:0] grad_abs(input logic signed [GRAD_W-1:0] v);
    return v[GRAD_W-1] ? -v : v;
  endfunction
endpackage

// File: rtl/sobel_line_buffer.sv
// One-row delay: tap is the value written DEPTH enabled cycles earlier; no added latency.
// Advances only while en is high, so it freezes with the stage under backpressure.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PIX_W-1:0] data,
  output logic [PIX_W-1:0] tap
);
  localparam int AW = $clog2(DEPTH);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  // Read-before-write at the same slot turns a circular buffer into a fixed delay.
  assign tap = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= data;
    end
  end
endmodule

// File: rtl/sobel_window_conv.sv
// Streaming 3x3 Sobel gx/gy over raster pixels; latency 2 cycles; SOBEL_ABS_EN selects |gx|,|gy|.
// Single global enable: out_valid && !out_ready freezes every stage and drops in_ready.
module sobel_window_conv
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  in_pix,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic [GRAD_W-1:0] gx,
  output logic [GRAD_W-1:0] gy,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic              en;
  logic              accept;
  logic [CW-1:0]     col;
  logic [CW-1:0]     cur_col;
  logic [RW-1:0]     row;
  logic [RW-1:0]     cur_row;
  logic              col_wrap;
  logic              row_wrap;
  logic [PIX_W-1:0]  prev_row_pix;
  logic [PIX_W-1:0]  old_row_pix;
  window_t           win;
  logic              s1_valid;
  logic              s1_last;
  logic signed [GRAD_W-1:0] gx_raw;
  logic signed [GRAD_W-1:0] gy_raw;
  logic signed [GRAD_W-1:0] gx_next;
  logic signed [GRAD_W-1:0] gy_next;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // in_sof pins this pixel to (0,0) and takes priority over any pending wrap.
  assign cur_col  = in_sof ? '0 : col;
  assign cur_row  = in_sof ? '0 : row;
  assign col_wrap = (cur_col == CW'(IMG_WIDTH - 1));
  assign row_wrap = (cur_row == RW'(IMG_HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= col_wrap ? '0 : cur_col + 1'b1;
      if (col_wrap) begin
        row <= row_wrap ? '0 : cur_row + 1'b1;
      end else begin
        row <= cur_row;
      end
    end
  end

  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_prev (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .data (in_pix),
    .tap  (prev_row_pix)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_old (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .data (prev_row_pix),
    .tap  (old_row_pix)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      win      <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_valid <= accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      s1_last  <= accept && row_wrap && col_wrap;
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= old_row_pix;
        win[1][2] <= prev_row_pix;
        win[2][2] <= in_pix;
      end
    end
  end

  // Pixels are zero-extended, so every partial sum stays within 11-bit signed range.
  always_comb begin
    gx_raw = (pix_ext(win[0][2]) + (pix_ext(win[1][2]) <<< 1) + pix_ext(win[2][2]))
           - (pix_ext(win[0][0]) + (pix_ext(win[1][0]) <<< 1) + pix_ext(win[2][0]));
    gy_raw = (pix_ext(win[2][0]) + (pix_ext(win[2][1]) <<< 1) + pix_ext(win[2][2]))
           - (pix_ext(win[0][0]) + (pix_ext(win[0][1]) <<< 1) + pix_ext(win[0][2]));
`ifdef SOBEL_ABS_EN
    gx_next = grad_abs(gx_raw);
    gy_next = grad_abs(gy_raw);
`else
    gx_next = gx_raw;
    gy_next = gy_raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gx        <= '0;
      gy        <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_last  <= s1_valid && s1_last;
      if (s1_valid) begin
        gx <= gx_next;
        gy <= gy_next;
      end
    end
  end
endmodule

// File: tb/tb_sobel_window_conv.sv
// Randomised frame bench for sobel_window_conv against an image-level Sobel model.
module tb_sobel_window_conv;
  localparam int W = 8;
  localparam int H = 6;

  logic        clk;
  logic        rst;
  logic [7:0]  in_pix;
  logic        in_valid;
  logic        in_sof;
  logic        in_ready;
  logic [10:0] gx;
  logic [10:0] gy;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;

  sobel_window_conv #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_pix    (in_pix),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .gx        (gx),
    .gy        (gy),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] gx;
    logic [10:0] gy;
    logic        last;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   img [H][W];
  exp_t exp_q [$];
  bit   drv_done;

  function automatic void fill(input int pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pat)
          0: img[r][c] = 100;
          1: img[r][c] = (c >= 4) ? 255 : 0;
          2: img[r][c] = (c >= 4) ? 0 : 255;
          3: img[r][c] = (r >= 3) ? 255 : 0;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
  endfunction

  // Each interior pixel (r,c) yields one output, in raster order.
  function automatic void build_expected();
    exp_q.delete();
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c++) begin
        int ex, ey;
        exp_t e;
        ex = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
        ey = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
`ifdef SOBEL_ABS_EN
        if (ex < 0) ex = -ex;
        if (ey < 0) ey = -ey;
`endif
        e.gx   = 11'(ex);
        e.gy   = 11'(ey);
        e.last = (r == H - 2) && (c == W - 2);
        exp_q.push_back(e);
      end
  endfunction

  task automatic drive(input int n, input bit gaps);
    int timeouts = 0;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      bit ok;
      int t;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_sof   = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_pix   = 8'(img[k / W][k % W]);
      in_sof   = (k == 0);
      t = 0;
      do begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk); #1;
        t++;
      end while (!ok && t < 1000);
      if (!ok) timeouts++;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    checks++;
    if (timeouts != 0) begin
      errors++;
      $display("FAIL drive_timeout: %0d pixels never accepted, required 0", timeouts);
    end
    drv_done = 1'b1;
  endtask

  task automatic collect(input int stall_at, input bit rnd_ready);
    int          n_exp = exp_q.size();
    int          got = 0;
    int          idle = 0;
    int          stall_cnt = 0;
    bit          stalling = 1'b0;
    logic [22:0] snap = '0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      if (stalling && out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: got %b, required 0", in_ready);
        end
        if (stall_cnt == 0) begin
          snap = {gx, gy, out_last};
        end else begin
          checks++;
          if ({gx, gy, out_last} !== snap) begin
            errors++;
            $display("FAIL stall_hold: got %h, required %h", {gx, gy, out_last}, snap);
          end
        end
        stall_cnt++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_output: got gx=%0d gy=%0d, required no output",
                   $signed(gx), $signed(gy));
        end else begin
          exp_t e = exp_q.pop_front();
          if (gx !== e.gx || gy !== e.gy || out_last !== e.last) begin
            errors++;
            $display("FAIL output_%0d: got gx=%0d gy=%0d last=%b, required gx=%0d gy=%0d last=%b",
                     got, $signed(gx), $signed(gy), out_last,
                     $signed(e.gx), $signed(e.gy), e.last);
          end
        end
        got++;
      end
      if (drv_done && !out_valid) idle++;
      else idle = 0;
      if (idle > 10) break;
      @(posedge clk); #1;
      if (stall_at >= 0 && got >= stall_at && stall_cnt < 5) begin
        stalling  = 1'b1;
        out_ready = 1'b0;
      end else begin
        stalling  = 1'b0;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    checks++;
    if (got != n_exp || exp_q.size() != 0) begin
      errors++;
      $display("FAIL output_count: got %0d, required %0d", got, n_exp);
    end
    if (stall_at >= 0) begin
      checks++;
      if (stall_cnt < 5) begin
        errors++;
        $display("FAIL stall_cycles: got %0d, required 5", stall_cnt);
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic run_frame(input int pat, input bit gaps, input bit rnd, input int stall_at);
    fill(pat);
    build_expected();
    drv_done = 1'b0;
    fork
      drive(W * H, gaps);
      collect(stall_at, rnd);
    join
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pix = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    if (out_last !== 1'b0)   begin errors++; $display("FAIL reset_out_last: got %b, required 0", out_last); end
    if (gx !== 11'd0)        begin errors++; $display("FAIL reset_gx: got %0d, required 0", gx); end
    if (gy !== 11'd0)        begin errors++; $display("FAIL reset_gy: got %0d, required 0", gy); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_patterns();
    for (int p = 0; p < 4; p++) run_frame(p, 1'b0, 1'b0, -1);
  endtask

  task automatic test_stall();
    run_frame(4, 1'b0, 1'b0, 10);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) run_frame(4, 1'b1, 1'b1, -1);
  endtask

  task automatic test_sof_resync();
    fill(4);
    build_expected();
    drv_done = 1'b0;
    fork
      begin
        drive(13, 1'b0);
        drv_done = 1'b0;
        drive(W * H, 1'b0);
      end
      collect(-1, 1'b0);
    join
  endtask

  task automatic test_mid_reset();
    fill(4);
    drv_done  = 1'b0;
    out_ready = 1'b1;
    drive(30, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b, required 0", out_valid); end
    if (out_last !== 1'b0)  begin errors++; $display("FAIL midreset_out_last: got %b, required 0", out_last); end
    run_frame(4, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_stall();
    test_back_to_back();
    test_sof_resync();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
